// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wptr_full_ctrl
//  Purpose  : Write-side pointer and full-flag controller for a dual-clock
//             Gray-pointer FIFO.  Everything runs in the write clock domain,
//             including the 2-flop synchroniser for the incoming Gray read
//             pointer.
//
//  Ports    : wclk         - write-domain clock (rising edge)
//             wrst         - synchronous, active-high reset
//             winc         - write request, honoured only while wfull=0
//             wclr_ovf     - clears the sticky overflow flag
//             wrptr        - Gray read pointer from the read domain (async)
//             waddr        - memory write address (low bits of binary pointer)
//             wptr         - registered Gray write pointer for the read domain
//             wfull        - registered full flag
//             walmost_full - registered, occupancy >= AFULL_THRESH
//             wlevel       - registered occupancy, 0..2^ADDRSIZE
//             woverflow    - sticky, a write was attempted while full
//
//  Revision : 1.0 - initial release
// ============================================================================
module wptr_full_ctrl #(
   parameter int ADDRSIZE     = 5,
   parameter int AFULL_THRESH = 28
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                winc,
   input  logic                wclr_ovf,
   input  logic [ADDRSIZE:0]   wrptr,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE:0]   wptr,
   output logic                wfull,
   output logic                walmost_full,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                woverflow
);

   localparam logic [ADDRSIZE:0] AF_LEVEL = AFULL_THRESH[ADDRSIZE:0];

   // Synchroniser stages for the read pointer.
   logic [ADDRSIZE:0] wq1;
   logic [ADDRSIZE:0] wq2;

   // Binary write pointer (one extra wrap bit above the address).
   logic [ADDRSIZE:0] wbin;

   logic              winc_ok;
   logic [ADDRSIZE:0] wbinnext;
   logic [ADDRSIZE:0] wgraynext;
   logic [ADDRSIZE:0] rbin_s;
   logic [ADDRSIZE:0] level_next;
   logic              wfull_val;

   // ------------------------------------------------------------------------
   // Gray-to-binary of the synchronised read pointer: each binary bit is the
   // XOR of all Gray bits at and above it.
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi <= ADDRSIZE; gi++) begin : g_gray2bin
         assign rbin_s[gi] = ^wq2[ADDRSIZE:gi];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Next-pointer, full and level arithmetic
   // ------------------------------------------------------------------------
   always_comb begin
      winc_ok    = winc & ~wfull;
      wbinnext   = wbin + {{ADDRSIZE{1'b0}}, winc_ok};
      wgraynext  = (wbinnext >> 1) ^ wbinnext;
      // Full when the write pointer is exactly one lap ahead of the read
      // pointer; in Gray code that means the top two bits are inverted and
      // the rest match.
      wfull_val  = (wgraynext == {~wq2[ADDRSIZE:ADDRSIZE-1], wq2[ADDRSIZE-2:0]});
      // Modular difference; the stale read pointer can only make this larger
      // than the true occupancy, never smaller.
      level_next = wbinnext - rbin_s;
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge wclk) begin
      if (wrst) begin
         wq1          <= '0;
         wq2          <= '0;
         wbin         <= '0;
         wptr         <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
         woverflow    <= 1'b0;
      end else begin
         wq1          <= wrptr;
         wq2          <= wq1;
         wbin         <= wbinnext;
         wptr         <= wgraynext;
         wfull        <= wfull_val;
         walmost_full <= (level_next >= AF_LEVEL);
         wlevel       <= level_next;
         // Set has priority over clear when both occur together.
         woverflow    <= (winc & wfull) | (woverflow & ~wclr_ovf);
      end
   end

   assign waddr = wbin[ADDRSIZE-1:0];

endmodule
`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wptr_full_ctrl
//  Purpose  : Self-checking bench for wptr_full_ctrl.  An occupancy-based
//             model (write count minus synchronised read count) is checked
//             against the DUT every cycle, and directed literal expectations
//             pin the model at key points.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wptr_full_ctrl;

   logic       wclk;
   logic       wrst;
   logic       winc;
   logic       wclr_ovf;
   logic [5:0] wrptr;
   logic [4:0] waddr;
   logic [5:0] wptr;
   logic       wfull;
   logic       walmost_full;
   logic [5:0] wlevel;
   logic       woverflow;

   int n_checks = 0;
   int n_fail   = 0;

   wptr_full_ctrl #(.ADDRSIZE(5), .AFULL_THRESH(28)) dut (
      .wclk         (wclk),
      .wrst         (wrst),
      .winc         (winc),
      .wclr_ovf     (wclr_ovf),
      .wrptr        (wrptr),
      .waddr        (waddr),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wlevel       (wlevel),
      .woverflow    (woverflow)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int gray(input int b);
      return (b ^ (b >> 1)) & 63;
   endfunction

   // Inverse Gray by search over the 64 code points.
   function automatic int ungray(input int g);
      for (int v = 0; v < 64; v++)
         if (gray(v) == g) return v;
      return -1;
   endfunction

   // ------------------------------------------------------------------------
   // Behavioural model: counts writes, tracks the read count as seen after
   // two synchroniser stages, and derives all flags from occupancy.
   // ------------------------------------------------------------------------
   bit m_valid = 0;
   int m_wcnt, m_q1, m_q2, m_level;
   bit m_full, m_af, m_ovf;

   always @(posedge wclk) begin
      if (wrst) begin
         m_valid = 1;
         m_wcnt = 0; m_q1 = 0; m_q2 = 0; m_level = 0;
         m_full = 0; m_af = 0; m_ovf = 0;
      end else if (m_valid) begin
         int accepted, wnext, occ;
         accepted = (winc && !m_full) ? 1 : 0;
         wnext    = (m_wcnt + accepted) % 64;
         occ      = (wnext - ungray(m_q2) + 64) % 64;
         m_ovf    = (winc && m_full) || (m_ovf && !wclr_ovf);
         m_full   = (occ == 32);
         m_af     = (occ >= 28);
         m_level  = occ;
         m_q2     = m_q1;
         m_q1     = int'(wrptr);
         m_wcnt   = wnext;
      end
   end

   always @(negedge wclk) begin
      if (m_valid) begin
         chk("model_waddr", waddr, m_wcnt % 32);
         chk("model_wptr", wptr, gray(m_wcnt));
         chk("model_wfull", wfull, m_full);
         chk("model_walmost_full", walmost_full, m_af);
         chk("model_wlevel", wlevel, m_level);
         chk("model_woverflow", woverflow, m_ovf);
      end
   end

   // ------------------------------------------------------------------------
   // Directed stimulus; inputs change on the falling edge.
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge wclk);
      @(negedge wclk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_waddr"}, waddr, 0);
      chk({tag, "_wptr"}, wptr, 0);
      chk({tag, "_wfull"}, wfull, 0);
      chk({tag, "_walmost_full"}, walmost_full, 0);
      chk({tag, "_wlevel"}, wlevel, 0);
      chk({tag, "_woverflow"}, woverflow, 0);
   endtask

   int rcnt;
   logic [5:0] prev_wptr;
   logic [5:0] diff;

   initial begin
      wrst = 1'b1; winc = 1'b1; wclr_ovf = 1'b0; wrptr = 6'b010101;

      // 1. reset held two cycles with activity on the inputs
      tick(); chk_reset_vals("rst1");
      tick(); chk_reset_vals("rst2");

      // 2. fill from empty
      wrst = 1'b0; wrptr = 6'b000000; winc = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         chk("fill_waddr", waddr, k - 1);
         tick();
         chk("fill_wlevel", wlevel, k);
         chk("fill_afull", walmost_full, (k >= 28) ? 1 : 0);
         chk("fill_wfull", wfull, (k == 32) ? 1 : 0);
      end
      chk("full_wptr", wptr, 6'b110000);
      chk("full_waddr", waddr, 0);

      // 3. rejected write while full sets overflow
      tick();
      chk("ovf_wptr", wptr, 6'b110000);
      chk("ovf_waddr", waddr, 0);
      chk("ovf_set", woverflow, 1);
      winc = 1'b0;
      tick(); tick();
      chk("ovf_hold", woverflow, 1);
      wclr_ovf = 1'b1;
      tick();
      chk("ovf_clear", woverflow, 0);
      wclr_ovf = 1'b0;

      // 4. read pointer advances to 8; release after three edges
      wrptr = 6'b001100;
      tick(); chk("rel_e1_wfull", wfull, 1);
      tick(); chk("rel_e2_wfull", wfull, 1);
      tick();
      chk("rel_e3_wfull", wfull, 0);
      chk("rel_e3_wlevel", wlevel, 24);
      chk("rel_e3_afull", walmost_full, 0);

      // 5. wrap with matching reads
      rcnt = 8;
      prev_wptr = wptr;
      for (int i = 0; i < 70; i++) begin
         winc  = 1'b1;
         rcnt  = rcnt + 1;
         wrptr = 6'(gray(rcnt % 64));
         tick();
         chk("wrap_wfull", wfull, 0);
         chk("wrap_level_le32", (wlevel <= 6'd32) ? 1 : 0, 1);
         diff = wptr ^ prev_wptr;
         chk("wrap_gray_step", ($countones(diff) <= 1) ? 1 : 0, 1);
         prev_wptr = wptr;
      end
      winc = 1'b0;
      chk("wrap_wptr", wptr, 6'b110101);
      chk("wrap_waddr", waddr, 6);
      tick(); tick(); tick();
      chk("wrap_settled_level", wlevel, 24);

      // 6. refill, then simultaneous overflow set and clear
      winc = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      chk("refill_wfull", wfull, 1);
      chk("refill_wlevel", wlevel, 32);
      wclr_ovf = 1'b1;
      tick();
      chk("setclr_ovf", woverflow, 1);
      chk("setclr_wptr", wptr, 6'b111001);
      winc = 1'b0;
      tick();
      chk("setclr_after", woverflow, 0);
      wclr_ovf = 1'b0;

      // mid-burst reset at level 10
      wrst = 1'b1; wrptr = 6'b000000;
      tick(); chk_reset_vals("rst3");
      wrst = 1'b0; winc = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      chk("burst_wlevel", wlevel, 10);
      wrst = 1'b1;
      tick(); chk_reset_vals("rst4");
      wrst = 1'b0; winc = 1'b0;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
